rs232_des: RTL and testbench
============================

# rs232_des

RS-232 deserializer: oversamples an asynchronous serial line and recovers 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit, no flow control). Each good byte is pushed into a downstream receive FIFO with a single-cycle write strobe. It is the receive-side counterpart of the team's RS-232 serializer, sharing its clock and baud parameters, and sits between the board RX pin and the command-parsing FIFO.

## Interface
- P_CLK_FREQ_HZ, 100000000, clk frequency in Hz.
- P_BAUD_RATE, 9600, line baud rate.
- clk  input  1  system clock; must be ≥ 4× baud.
- rst_n  input  1  reset: synchronous, active-low; clock clk.
- rx  input  1  asynchronous serial line; idle high.
- rx_fifo_data  output  8  received byte; valid when rx_fifo_wr_en is high; holds until the next write.
- rx_fifo_wr_en  output  1  one-cycle write strobe to the FIFO.
- rx_fifo_full  input  1  FIFO full flag; when high, no write is issued.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overflow  output  1  one-cycle pulse: good byte dropped because rx_fifo_full was high.
- busy  output  1  high while the FSM is outside S_IDLE.

## Operation
- BIT_CNT_MAX = P_CLK_FREQ_HZ/P_BAUD_RATE (integer division).
- HALF_CNT = BIT_CNT_MAX/2.
- bit_cnt width = clogb2(BIT_CNT_MAX). bit_cnt wraps to 0 at BIT_CNT_MAX, so each bit lasts BIT_CNT_MAX+1 clocks, matching the serializer.
- rx passes through a 2-flop synchronizer (both flops reset to 1) into rx_s. Edge detection uses a third flop, rx_d.
- FSM states:
  - S_IDLE: bit_cnt=0, shift_cnt=0. On falling edge (rx_d=1, rx_s=0) → S_START.
  - S_START: count up. When bit_cnt==HALF_CNT, sample the line:
    - 0 → clear bit_cnt, go to S_DATA.
    - 1 → false start; return to S_IDLE with no outputs.
  - S_DATA: count up. When bit_cnt==BIT_CNT_MAX, sample, shift_reg <= {sample, shift_reg[7:1]}, clear bit_cnt. After the 8th sample (shift_cnt==7) → S_STOP.
  - S_STOP: count up. When bit_cnt==BIT_CNT_MAX, sample, then → S_IDLE (exits at mid-stop-bit for resync):
    - sample=1 and !rx_fifo_full → load rx_fifo_data, pulse rx_fifo_wr_en.
    - sample=1 and rx_fifo_full → pulse overflow; rx_fifo_data unchanged.
    - sample=0 → pulse frame_err, no write.
  - Undefined state → S_IDLE.
- After a frame error with the line held low (break), no new start is detected until rx_s has returned high.
- rx_fifo_full is sampled only in the stop-sample cycle.

## Timing
- Reset values: rx_fifo_data=8'h00, rx_fifo_wr_en=0, frame_err=0, overflow=0, busy=0, FSM=S_IDLE. Reset mid-frame aborts the frame with no write and no error pulse.
- Line falling edge → S_START entry: 3 clk (2 sync flops + edge register).
- rx_fifo_wr_en, frame_err and overflow are registered. They assert the cycle after the stop sample, for exactly 1 cycle, and are mutually exclusive.
- Back-to-back frames with no idle gap between stop and next start are received without loss.
- Receiver tolerates ±4% baud mismatch.

## Configuration
- RS232_DES_MAJORITY_EN defined: each sample point takes a 2-of-3 majority of rx_s at counts C-1, C, C+1, where C = HALF_CNT (start bit) or BIT_CNT_MAX (data/stop). Requires BIT_CNT_MAX ≥ 4. Rejects single-clock glitches at the sample point.
- Undefined: single sample of rx_s at count C. Output timing is identical either way.

## Test plan
Bench parameters: P_CLK_FREQ_HZ=1000000, P_BAUD_RATE=100000 (BIT_CNT_MAX=10, 11 clk/bit).
- Send 0xA5 8N1 → exactly one rx_fifo_wr_en pulse with rx_fifo_data=0xA5; frame_err=0, overflow=0; busy returns low.
- Send 0x00 then 0xFF back-to-back, no idle gap → two writes, 0x00 then 0xFF.
- Send 0x3C with the stop bit driven low → one frame_err pulse, no write, rx_fifo_data unchanged.
- Drive a 3-clk low glitch on an idle line → false start, return to S_IDLE, no outputs.
- Hold rx_fifo_full=1, send 0x55 → one overflow pulse, no rx_fifo_wr_en. Release full, send 0x55 → write 0x55.
- Assert rst_n=0 for 1 clk mid-byte during bit 4 → all outputs at reset values. Next frame 0x81 is received correctly.
- With RS232_DES_MAJORITY_EN defined, inject a 1-clk inverted glitch at a data-bit centre of 0x5A → 0x5A still received.

Source files
------------

// File: rtl/rs232_des_if.sv
// Receive-FIFO write port of the RS-232 deserializer: byte, write strobe, full flag.
// The master (deserializer) drives the byte and strobe; the slave (FIFO) drives full.
interface rs232_des_if;
  logic [7:0] rx_fifo_data;
  logic       rx_fifo_wr_en;
  logic       rx_fifo_full;

  modport master (output rx_fifo_data, output rx_fifo_wr_en, input rx_fifo_full);
  modport slave  (input rx_fifo_data, input rx_fifo_wr_en, output rx_fifo_full);
endinterface

// File: rtl/rs232_des.sv
// 8N1 RS-232 receiver: one-cycle FIFO write strobe after the stop sample; drops the byte with an overflow pulse when full.
// Define RS232_DES_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module rs232_des #(
  parameter int P_CLK_FREQ_HZ = 100000000,
  parameter int P_BAUD_RATE   = 9600
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  rs232_des_if.master  fifo,
  output logic         frame_err,
  output logic         overflow,
  output logic         busy
);

  localparam int BIT_CNT_MAX = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam int HALF_CNT    = BIT_CNT_MAX / 2;
  localparam int CW          = $clog2(BIT_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_CNT_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_CNT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    shift_cnt_q, shift_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          wr_q, wr_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic          sample;

  // rx_d_q holds rx_s one clock back and rx_meta_q one clock ahead, so the
  // majority window C-1..C+1 is available at count C without shifting timing.
`ifdef RS232_DES_MAJORITY_EN
  assign sample = (rx_d_q & rx_s_q) | (rx_d_q & rx_meta_q) | (rx_s_q & rx_meta_q);
`else
  assign sample = rx_s_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_cnt_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_d_q      <= rx_s_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_cnt_d = shift_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    ferr_d      = 1'b0;
    ovf_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d   = '0;
        shift_cnt_d = '0;
        if (rx_d_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (bit_cnt_q == CNT_HALF) begin
          bit_cnt_d = '0;
          state_d   = sample ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == CNT_MAX) begin
          bit_cnt_d   = '0;
          shift_d     = {sample, shift_q[7:1]};
          shift_cnt_d = shift_cnt_q + 3'd1;
          if (shift_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == CNT_MAX) begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          bit_cnt_d = '0;
          state_d   = S_IDLE;
          if (!sample) begin
            ferr_d = 1'b1;
          end else if (fifo.rx_fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            data_d = shift_q;
            wr_d   = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo.rx_fifo_data  = data_q;
  assign fifo.rx_fifo_wr_en = wr_q;
  assign frame_err          = ferr_q;
  assign overflow           = ovf_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs232_des.sv
// Directed bench for rs232_des at 1 MHz / 100 kbaud (11 clocks per bit).
module tb_rs232_des;
  logic clk;
  logic rst_n;
  logic rx;
  logic frame_err;
  logic overflow;
  logic busy;

  rs232_des_if fifo_if ();

  rs232_des #(
    .P_CLK_FREQ_HZ(1000000),
    .P_BAUD_RATE  (100000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .fifo     (fifo_if),
    .frame_err(frame_err),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int excl_cnt = 0;
  logic [7:0] wr_q[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_if.rx_fifo_wr_en === 1'b1) begin
        wr_cnt++;
        wr_q.push_back(fifo_if.rx_fifo_data);
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (overflow === 1'b1) ovf_cnt++;
      if (int'(fifo_if.rx_fifo_wr_en === 1'b1) + int'(frame_err === 1'b1) + int'(overflow === 1'b1) > 1)
        excl_cnt++;
    end
  end

  // Called at a negedge; drives a full 8N1 frame, optionally inverting one
  // clock near the centre of data bit glitch_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
    rx = 1'b0;
    repeat (11) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 11; j++) begin
        rx = (glitch_bit == i && j == 6) ? ~b[i] : b[i];
        @(negedge clk);
      end
    end
    rx = stop;
    repeat (11) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    fifo_if.rx_fifo_full = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({fifo_if.rx_fifo_data, fifo_if.rx_fifo_wr_en, frame_err, overflow, busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h wr=%b ferr=%b ovf=%b busy=%b, want all 0",
               fifo_if.rx_fifo_data, fifo_if.rx_fifo_wr_en, frame_err, overflow, busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int w0 = wr_cnt, f0 = ferr_cnt, o0 = ovf_cnt;
    logic [7:0] got;
    send_frame(8'hA5, 1'b1, -1);
    repeat (20) @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 1) begin
      bad++; $display("FAIL single_wr_count: got %0d want 1", wr_cnt - w0);
    end
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
    total++;
    if (got !== 8'hA5) begin
      bad++; $display("FAIL single_data: got %h want a5", got);
    end
    total++;
    if ((ferr_cnt - f0) + (ovf_cnt - o0) !== 0) begin
      bad++; $display("FAIL single_errs: got ferr=%0d ovf=%0d want 0 0", ferr_cnt - f0, ovf_cnt - o0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt;
    logic [7:0] g0, g1;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    repeat (20) @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 2) begin
      bad++; $display("FAIL b2b_wr_count: got %0d want 2", wr_cnt - w0);
    end
    g0 = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
    g1 = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
    total++;
    if (g0 !== 8'h00 || g1 !== 8'hFF) begin
      bad++; $display("FAIL b2b_data: got %h %h want 00 ff", g0, g1);
    end
  endtask

  task automatic test_frame_err();
    int w0 = wr_cnt, f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1);
    repeat (20) @(negedge clk);
    total++;
    if (ferr_cnt - f0 !== 1 || wr_cnt - w0 !== 0) begin
      bad++; $display("FAIL ferr_pulse: got ferr=%0d wr=%0d want 1 0", ferr_cnt - f0, wr_cnt - w0);
    end
    total++;
    if (fifo_if.rx_fifo_data !== 8'hFF) begin
      bad++; $display("FAIL ferr_data_hold: got %h want ff", fifo_if.rx_fifo_data);
    end
  endtask

  task automatic test_false_start();
    int w0 = wr_cnt, f0 = ferr_cnt, o0 = ovf_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL false_start_entry: got busy=%b want 1", busy);
    end
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b0 || wr_cnt != w0 || ferr_cnt != f0 || ovf_cnt != o0) begin
      bad++; $display("FAIL false_start_quiet: got busy=%b wr=%0d ferr=%0d ovf=%0d want 0 0 0 0",
                      busy, wr_cnt - w0, ferr_cnt - f0, ovf_cnt - o0);
    end
  endtask

  task automatic test_overflow();
    int w0 = wr_cnt, o0 = ovf_cnt;
    logic [7:0] got;
    fifo_if.rx_fifo_full = 1'b1;
    send_frame(8'h55, 1'b1, -1);
    repeat (20) @(negedge clk);
    total++;
    if (ovf_cnt - o0 !== 1 || wr_cnt - w0 !== 0) begin
      bad++; $display("FAIL ovf_pulse: got ovf=%0d wr=%0d want 1 0", ovf_cnt - o0, wr_cnt - w0);
    end
    total++;
    if (fifo_if.rx_fifo_data !== 8'hFF) begin
      bad++; $display("FAIL ovf_data_hold: got %h want ff", fifo_if.rx_fifo_data);
    end
    fifo_if.rx_fifo_full = 1'b0;
    send_frame(8'h55, 1'b1, -1);
    repeat (20) @(negedge clk);
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
    total++;
    if (wr_cnt - w0 !== 1 || got !== 8'h55) begin
      bad++; $display("FAIL ovf_release: got wr=%0d data=%h want 1 55", wr_cnt - w0, got);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt, f0 = ferr_cnt, o0 = ovf_cnt;
    logic [7:0] got;
    rx = 1'b0;
    repeat (11 + 4 * 11 + 5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    total++;
    if ({fifo_if.rx_fifo_data, fifo_if.rx_fifo_wr_en, frame_err, overflow, busy} !== 12'h000) begin
      bad++;
      $display("FAIL mid_reset_outputs: got data=%h wr=%b ferr=%b ovf=%b busy=%b, want all 0",
               fifo_if.rx_fifo_data, fifo_if.rx_fifo_wr_en, frame_err, overflow, busy);
    end
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    total++;
    if (wr_cnt != w0 || ferr_cnt != f0 || ovf_cnt != o0) begin
      bad++; $display("FAIL mid_abort_quiet: got wr=%0d ferr=%0d ovf=%0d want 0 0 0",
                      wr_cnt - w0, ferr_cnt - f0, ovf_cnt - o0);
    end
    send_frame(8'h81, 1'b1, -1);
    repeat (20) @(negedge clk);
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
    total++;
    if (wr_cnt - w0 !== 1 || got !== 8'h81) begin
      bad++; $display("FAIL mid_next_frame: got wr=%0d data=%h want 1 81", wr_cnt - w0, got);
    end
  endtask

`ifdef RS232_DES_MAJORITY_EN
  task automatic test_majority();
    int w0 = wr_cnt;
    logic [7:0] got;
    send_frame(8'h5A, 1'b1, 3);
    repeat (20) @(negedge clk);
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
    total++;
    if (wr_cnt - w0 !== 1 || got !== 8'h5A) begin
      bad++; $display("FAIL majority_glitch: got wr=%0d data=%h want 1 5a", wr_cnt - w0, got);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    fifo_if.rx_fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_false_start();
    test_overflow();
    test_reset_mid();
`ifdef RS232_DES_MAJORITY_EN
    test_majority();
`endif
    total++;
    if (excl_cnt !== 0) begin
      bad++; $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", excl_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
